// File: rtl/prism_sp_lmem_pkg.sv
// Shared types for the SP local-memory access port: FSM states, response beat
// layout and the address-to-bank decode helper.
package prism_sp_lmem_pkg;

  localparam int LMEM_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_ERR
  } lmem_state_t;

  typedef struct packed {
    logic [LMEM_DW-1:0] rdata;
    logic               err;
    logic               last;
  } lmem_rsp_t;

  // Bank field sits directly above the word field; a single bank always decodes to 0.
  function automatic logic [63:0] bank_of(input logic [63:0] addr, input int lsb, input int nbanks);
    if (nbanks <= 1) return '0;
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/prism_sp_lmem_rsp_fifo.sv
// Small synchronous FIFO holding response beats between the BRAM read pipe
// and the host response channel.
module prism_sp_lmem_rsp_fifo
  import prism_sp_lmem_pkg::*;
#(
  parameter type T     = lmem_rsp_t,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock)
    if (do_push) mem[wptr] <= din;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop)  rptr <= inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prism_sp_lmem_access_port.sv
// Host request/response port onto the B side of the SP local BRAMs: single
// writes, burst reads with credit-throttled issue into a latency-sized skid FIFO.
module prism_sp_lmem_access_port
  import prism_sp_lmem_pkg::*;
#(
  parameter int  NBANKS       = 3,
  parameter int  DATA_WIDTH   = 32,
  parameter int  BANK_AW      = 12,
  parameter int  READ_LATENCY = 1,
  parameter int  LEN_WIDTH    = 8,
  localparam int BE_W         = DATA_WIDTH / 8,
  localparam int OFF_W        = $clog2(BE_W),
  localparam int SEL_W        = $clog2(NBANKS),
  localparam int AW           = SEL_W + BANK_AW + OFF_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [AW-1:0]                    req_addr,
  input  logic [LEN_WIDTH-1:0]             req_len,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [BE_W-1:0]                  req_wstrb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_last,
  output logic [NBANKS-1:0]                mem_en,
  output logic [NBANKS-1:0][BE_W-1:0]      mem_be,
  output logic [BANK_AW-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [NBANKS-1:0][DATA_WIDTH-1:0] mem_dout
);

  localparam int DEPTH = READ_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (NBANKS > 1) ? SEL_W : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  last;
  } rsp_t;

  lmem_state_t             state, state_nxt;
  logic [BW-1:0]           bank_r;
  logic [BANK_AW-1:0]      addr_r;
  logic [LEN_WIDTH-1:0]    left_r;
  logic [DATA_WIDTH-1:0]   din_r;
  logic [BE_W-1:0]         wstrb_r;
  logic [CW-1:0]           credit;
  logic [READ_LATENCY-1:0] vld_pipe, last_pipe;
  logic [63:0]             req_bank;
  logic                    bank_ok, accept, pop, issue, take, push_rd, push;
  logic                    fifo_empty, fifo_full;
  logic [CW-1:0]           fifo_count;
  rsp_t                    push_rsp, head, rsp_q;

  assign req_bank = bank_of(64'(req_addr), OFF_W + BANK_AW, NBANKS);
  assign bank_ok  = (req_bank < 64'(NBANKS));
  assign accept   = req_valid && req_ready;
  assign pop      = rsp_valid && rsp_ready;

  always_ff @(posedge clock)
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (req_valid) state_nxt = !bank_ok ? ST_ERR : (req_write ? ST_WRITE : ST_READ);
      ST_WRITE: state_nxt = ST_DRAIN;
      ST_ERR:   state_nxt = ST_DRAIN;
      ST_READ:  if (issue && left_r == '0) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_count == '0 && vld_pipe == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so issue may reuse it immediately;
  // that bypass is what sustains one word per cycle with only L+1 entries.
  always_comb begin
    req_ready = (state == ST_IDLE);
    issue     = (state == ST_READ) && ((credit != '0 && !fifo_full) || pop);
    take      = issue || state == ST_WRITE || state == ST_ERR;
    push_rd   = vld_pipe[READ_LATENCY-1];
    push      = push_rd || state == ST_WRITE || state == ST_ERR;
    mem_en    = '0;
    mem_be    = '0;
    if (issue || state == ST_WRITE) mem_en[bank_r] = 1'b1;
    if (state == ST_WRITE)          mem_be[bank_r] = wstrb_r;
    push_rsp.rdata = push_rd ? mem_dout[bank_r] : '0;
    push_rsp.err   = (state == ST_ERR);
    push_rsp.last  = push_rd ? last_pipe[READ_LATENCY-1] : 1'b1;
  end

  assign mem_addr = addr_r;
  assign mem_din  = din_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_r  <= '0;
      addr_r  <= '0;
      left_r  <= '0;
      din_r   <= '0;
      wstrb_r <= '0;
    end else if (accept) begin
      bank_r  <= BW'(req_bank);
      addr_r  <= req_addr[OFF_W +: BANK_AW];
      left_r  <= req_len;
      din_r   <= req_wdata;
      wstrb_r <= req_wstrb;
    end else if (issue) begin
      addr_r  <= addr_r + 1'b1;
      left_r  <= left_r - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      credit    <= CW'(DEPTH);
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && left_r == '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      if (take && !pop)      credit <= credit - 1'b1;
      else if (pop && !take) credit <= credit + 1'b1;
    end
  end

  prism_sp_lmem_rsp_fifo #(
    .T     (rsp_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_rsp),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Head storage is not reset, so mask it while empty.
  assign rsp_q     = fifo_empty ? '0 : head;
  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign rsp_last  = rsp_q.last;

endmodule

// File: tb/tb_prism_sp_lmem_access_port.sv
// Directed bench for the SP local-memory access port with a 3-bank, latency-2
// BRAM model preloaded with a per-bank/per-word pattern.
module tb_prism_sp_lmem_access_port;

  localparam int NB = 3, DW = 32, BAW = 12, RL = 2, LW = 8, AW = 16;

  logic                   clock = 1'b0, reset = 1'b1;
  logic                   req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0]          req_addr = '0;
  logic [LW-1:0]          req_len = '0;
  logic [DW-1:0]          req_wdata = '0;
  logic [3:0]             req_wstrb = '0;
  logic                   rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_last;
  logic [DW-1:0]          rsp_rdata;
  logic [NB-1:0]          mem_en;
  logic [NB-1:0][3:0]     mem_be;
  logic [BAW-1:0]         mem_addr;
  logic [DW-1:0]          mem_din;
  logic [NB-1:0][DW-1:0]  mem_dout;

  always #5 clock = ~clock;

  prism_sp_lmem_access_port #(
    .NBANKS(NB), .DATA_WIDTH(DW), .BANK_AW(BAW), .READ_LATENCY(RL), .LEN_WIDTH(LW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [31:0] pat(input int b, input int w);
    return {8'hA0 + 8'(b), 8'h5C, 16'(w)};
  endfunction

  // BRAM model: address sampled at the edge, data two cycles after it was presented.
  logic [DW-1:0]         ram [NB][1<<BAW];
  logic [NB-1:0][DW-1:0] s1, dout;
  assign mem_dout = dout;

  always @(posedge clock) begin
    if (reset)
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < (1<<BAW); w++) ram[b][w] <= pat(b, w);
    for (int b = 0; b < NB; b++) begin
      if (mem_en[b]) begin
        for (int j = 0; j < 4; j++)
          if (mem_be[b][j]) ram[b][mem_addr][8*j +: 8] <= mem_din[8*j +: 8];
        s1[b] <= ram[b][mem_addr];
      end
      dout[b] <= s1[b];
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] bd[$];
  bit          berr[$], blast[$];
  int          bidx[$];
  int          en_pulses, wr_pulses, multi_en, max_out;
  logic [2:0]  en_last;
  logic [11:0] be_last;

  task automatic send(input bit wr, input logic [15:0] a, input int len,
                      input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clock); #1; n++; end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = 8'(len);
    req_wdata = wd; req_wstrb = ws;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  // mode 0: rsp_ready held high; mode 1: 10-cycle hold-off then toggling.
  // Cycle index 0 is the cycle right after the accepting edge.
  task automatic collect(input string tag, input int mode);
    int issued = 0, taken = 0, i = 0, tail = -1;
    bit got_last = 0;
    bd.delete(); berr.delete(); blast.delete(); bidx.delete();
    en_pulses = 0; wr_pulses = 0; multi_en = 0; max_out = 0;
    en_last = '0; be_last = '0;
    while (i < 200 && tail != 0) begin
      rsp_ready = (mode == 0) ? 1'b1 : (i >= 10 && i % 2 == 0);
      @(negedge clock);
      if (mem_en != '0) begin
        en_pulses++; en_last = mem_en; be_last = mem_be;
        if (!$onehot(mem_en)) multi_en++;
        if (mem_be == '0) issued++; else wr_pulses++;
      end
      if (rsp_valid && rsp_ready) begin
        bd.push_back(rsp_rdata); berr.push_back(rsp_err);
        blast.push_back(rsp_last); bidx.push_back(i);
        taken++;
        if (rsp_last && !got_last) begin got_last = 1; tail = 3; end
      end
      if (issued - taken > max_out) max_out = issued - taken;
      @(posedge clock); #1;
      i++;
      if (tail > 0) tail--;
    end
    rsp_ready = 1'b1;
    chk({tag, " completed"}, 64'(got_last), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, nlast, nb;

    // reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_err",   64'(rsp_err),   64'd0);
    chk("rst rsp_last",  64'(rsp_last),  64'd0);
    chk("rst mem_en",    64'(mem_en),    64'd0);
    chk("rst mem_be",    64'(mem_be),    64'd0);
    chk("rst mem_addr",  64'(mem_addr),  64'd0);

    // full write to bank1 word5, then read it back
    send(1, 16'h4014, 0, 32'hDEADBEEF, 4'hF);
    collect("wr1", 0);
    chk("wr1 en pulses", 64'(en_pulses), 64'd1);
    chk("wr1 mem_en",    64'(en_last),   64'h2);
    chk("wr1 mem_be",    64'(be_last),   64'h0F0);
    chk("wr1 beats",     64'(bd.size()), 64'd1);
    chk("wr1 ack",       {bd[0], 30'd0, berr[0], blast[0]}, {32'd0, 30'd0, 1'b0, 1'b1});

    send(0, 16'h4014, 0, 32'h0, 4'h0);
    collect("rd1", 0);
    chk("rd1 beats", 64'(bd.size()), 64'd1);
    chk("rd1 beat",  {bd[0], 30'd0, berr[0], blast[0]}, {32'hDEADBEEF, 30'd0, 1'b0, 1'b1});
    chk("rd1 no be", 64'(wr_pulses), 64'd0);

    // partial strobe on bank2 word7
    send(1, 16'h801C, 0, 32'hFFFFFFFF, 4'hF);
    collect("wr2", 0);
    send(1, 16'h801C, 0, 32'h12345678, 4'h3);
    collect("wr3", 0);
    chk("wr3 mem_be", 64'(be_last), 64'h300);
    send(0, 16'h801C, 0, 32'h0, 4'h0);
    collect("rd2", 0);
    chk("partial strobe data", 64'(bd[0]), 64'hFFFF5678);

    // streaming burst, bank0 words 0x10..0x1F
    send(0, 16'h0040, 15, 32'h0, 4'h0);
    collect("stream", 0);
    errs = 0; nlast = 0;
    foreach (bd[j]) begin
      if (bd[j] !== pat(0, 16 + j) || berr[j]) errs++;
      if (blast[j]) nlast++;
    end
    chk("stream beats",      64'(bd.size()), 64'd16);
    chk("stream data",       64'(errs),      64'd0);
    chk("stream last count", 64'(nlast),     64'd1);
    chk("stream last beat",  64'(blast[15]), 64'd1);
    chk("stream first idx",  64'(bidx[0]),   64'(RL + 1));
    chk("stream span",       64'(bidx[15] - bidx[0]), 64'd15);
    chk("stream onehot",     64'(multi_en),  64'd0);

    // same burst under backpressure
    send(0, 16'h0040, 15, 32'h0, 4'h0);
    collect("bp", 1);
    errs = 0; nlast = 0;
    foreach (bd[j]) begin
      if (bd[j] !== pat(0, 16 + j) || berr[j]) errs++;
      if (blast[j]) nlast++;
    end
    chk("bp beats",       64'(bd.size()), 64'd16);
    chk("bp data",        64'(errs),      64'd0);
    chk("bp last",        64'(nlast + 64'(blast[15])), 64'd2);
    chk("bp outstanding", 64'(max_out),   64'd3);
    chk("bp issues",      64'(en_pulses), 64'd16);

    // wrap within bank2 at the top word
    send(0, 16'hBFFC, 1, 32'h0, 4'h0);
    collect("wrap", 0);
    chk("wrap beats", 64'(bd.size()), 64'd2);
    chk("wrap w0",    64'(bd[0]),     64'(pat(2, 4095)));
    chk("wrap w1",    64'(bd[1]),     64'(pat(2, 0)));
    chk("wrap last",  {62'd0, blast[0], blast[1]}, 64'b01);

    // bad bank: write and read burst each give one error beat, no enable
    send(1, 16'hC000, 0, 32'hCAFEF00D, 4'hF);
    collect("errw", 0);
    chk("errw beats", 64'(bd.size()), 64'd1);
    chk("errw beat",  {bd[0], 30'd0, berr[0], blast[0]}, {32'd0, 30'd0, 1'b1, 1'b1});
    chk("errw no en", 64'(en_pulses), 64'd0);
    send(0, 16'hC004, 5, 32'h0, 4'h0);
    collect("errr", 0);
    chk("errr beats", 64'(bd.size()), 64'd1);
    chk("errr beat",  {bd[0], 30'd0, berr[0], blast[0]}, {32'd0, 30'd0, 1'b1, 1'b1});
    chk("errr no en", 64'(en_pulses), 64'd0);

    // reset while beat 4 of 16 is presented
    send(0, 16'h0040, 15, 32'h0, 4'h0);
    rsp_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 60 && nb < 4; c++) begin
      @(negedge clock);
      if (rsp_valid) nb++;
      if (nb < 4) begin @(posedge clock); #1; end
    end
    chk("rst reached beat4", 64'(nb), 64'd4);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst req_ready", 64'(req_ready), 64'd1);
    nb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (rsp_valid || mem_en != '0) nb++;
      @(posedge clock); #1;
    end
    chk("midrst quiet", 64'(nb), 64'd0);
    send(0, 16'h0080, 0, 32'h0, 4'h0);
    collect("post rst", 0);
    chk("post rst beats", 64'(bd.size()), 64'd1);
    chk("post rst beat",  {bd[0], 30'd0, berr[0], blast[0]}, {pat(0, 32), 30'd0, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prism_sp_lmem_access_port.md
Name: prism_sp_lmem_access_port

Overview:
Parametrised host-side access port to NBANKS local memories (instruction, data, ACP BRAM and any added later) of one SP processor. It replaces per-bank direct MMR wiring with a single request/response channel. It decodes the bank from the address, supports single writes and burst reads, and absorbs response backpressure through a credit-controlled skid FIFO sized to the BRAM read latency. It sits between the MMR fabric and the B ports of the processor's true-dual-port BRAMs.

Parameters:
NBANKS, 3, number of attached memories; ≥1.
DATA_WIDTH, 32, word width; multiple of 8.
BANK_AW, 12, word-address width per bank.
READ_LATENCY, 1, BRAM read latency in cycles; 1..4.
LEN_WIDTH, 8, burst-length field width; a burst is req_len+1 words.

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=single write, 0=burst read
req_addr  in  AW=$clog2(NBANKS)+BANK_AW+$clog2(DATA_WIDTH/8)  byte address; low byte-offset bits ignored
req_len  in  LEN_WIDTH  read words minus 1; ignored for writes
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  byte enables
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response beat consumed when valid&ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for write ack and error
rsp_err  out  1  bank index ≥ NBANKS
rsp_last  out  1  final beat of a transaction
mem_en  out  NBANKS  per-bank enable
mem_be  out  NBANKS×DATA_WIDTH/8  per-bank byte write enables
mem_addr  out  BANK_AW  shared word address
mem_din  out  DATA_WIDTH  shared write data
mem_dout  in  NBANKS×DATA_WIDTH  per-bank read data

Behaviour:
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_last=0; mem_en=0; mem_be=0; mem_addr=0; FIFO empty; credits=FIFO depth. Reset mid-burst abandons the burst and drops in-flight data; no beat is emitted after reset.
- Decode: bank = req_addr[AW-1 -: $clog2(NBANKS)] (0 when NBANKS=1); word = next BANK_AW bits.
- FSM IDLE/WRITE/READ/DRAIN/ERR; req_ready=1 only in IDLE.
- IDLE→ERR on accept with bank≥NBANKS: no mem_en. One beat is emitted: rsp_err=1, rsp_last=1, rdata=0. It is held until rsp_ready, then the FSM returns to IDLE. A read burst with a bad bank also produces exactly one error beat.
- IDLE→WRITE on a valid write. Next cycle: mem_en[bank]=1, mem_be[bank]=req_wstrb, addr/din driven for one cycle. An ack beat (err=0, last=1, rdata=0) is pushed into the FIFO, held until consumed, then IDLE.
- IDLE→READ on a valid read. Registered bank, addr and remaining count. Each cycle with credit>0 and words remaining: mem_en[bank]=1, mem_be=0, decrement credit, increment the word address modulo 2^BANK_AW (wraps within the bank, never crosses banks).
- After the last issue, READ→DRAIN. DRAIN→IDLE once the FIFO is empty and no reads are in flight.
- Read data is captured from mem_dout[bank] exactly READ_LATENCY cycles after issue, via a valid shift register of length READ_LATENCY. It is pushed into the FIFO with last set on the final word.
- FIFO depth = READ_LATENCY+1. Credit +1 on each pop, −1 on each issue; a simultaneous pop and issue leaves credit unchanged. Credits never go negative and the FIFO never overflows.
- Sustained throughput with rsp_ready held 1 is 1 word/cycle. First-beat latency from accept is READ_LATENCY+2 cycles (1 register cycle, READ_LATENCY, 1 FIFO output).
- Response outputs come from the FIFO head; rsp_valid = !empty. Beats stay stable while valid&!ready.
- mem_be is never nonzero in the READ state; at most one mem_en bit is high per cycle.

Decomposition:
- prism_sp_lmem_pkg holds the state enum lmem_state_t, response struct lmem_rsp_t {rdata, err, last}, and the function bank_of().
- Sub-module prism_sp_lmem_rsp_fifo: synchronous FIFO of lmem_rsp_t with parametrised depth and push/pop/empty/full/count.

Test Plan:
- Write then read: write 0xDEADBEEF, wstrb=0xF, to bank1 word 5 (byte addr 0x4014) → mem_en=3'b010 and be=0xF for one cycle, ack beat last=1. A read with len=0 at the same address returns 0xDEADBEEF, last=1, err=0.
- Partial strobe: wstrb=0x3 with data 0x12345678 over 0xFFFFFFFF → the read returns 0xFFFF5678.
- Streaming: bank0 burst len=15, rsp_ready=1, READ_LATENCY=2 → 16 beats on consecutive cycles, first beat 4 cycles after accept, last only on beat 16.
- Backpressure: same burst, rsp_ready toggling 1/0 each cycle plus a 10-cycle hold-off → no lost or duplicated beats, data in order, FIFO count ≤3, mem_en idles while credit=0.
- Wrap and error: a read at word 2^BANK_AW−1 with len=1 returns words max and 0 of the same bank. A bank=3 request with NBANKS=3 gives one beat err=1, last=1, and no mem_en pulse.
- Reset mid-burst: assert reset during beat 4 of 16 → rsp_valid=0 next cycle, req_ready=1. A fresh len=0 read then completes correctly.
